// File: rtl/median_filter_pkg.sv
// Shared types and helpers for the vertical median filter with internal line buffers.
package median_filter_pkg;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DRAIN} state_t;

    // All-ones disparity marks an invalid pixel; narrowed to WIDTH at the use site.
    localparam logic [31:0] INVALID_DISP = '1;

    function automatic int rank_width(input int rmax);
        return (rmax > 0) ? $clog2(2 * rmax + 1) : 1;
    endfunction

endpackage

// File: rtl/median_rank_select.sv
// Rank-based median of a masked tap vector: S2 computes per-tap ranks, S3 picks the lower median.
module median_rank_select
    import median_filter_pkg::*;
#(
    parameter int WIDTH = 9,
    parameter int NTAP  = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clken,
    input  logic                       tap_vld,
    input  logic                       tap_last,
    input  logic [NTAP-1:0][WIDTH-1:0] tap,
    input  logic [NTAP-1:0]            mask,
    output logic                       med_vld,
    output logic                       med_last,
    output logic [WIDTH-1:0]           med
);

    localparam int RANK_W = rank_width((NTAP - 1) / 2);

    logic [RANK_W-1:0]          rank_c [NTAP];
    logic [RANK_W-1:0]          tgt_c;
    logic [RANK_W-1:0]          rank_p1 [NTAP];
    logic [RANK_W-1:0]          tgt_p1;
    logic [NTAP-1:0][WIDTH-1:0] tap_p1;
    logic [NTAP-1:0]            mask_p1;
    logic                       vld_p1;
    logic                       last_p1;
    logic [WIDTH-1:0]           sel_c;

    // Ties resolve by tap index, so active ranks always form a permutation of 0..n-1.
    always_comb begin
        int n;
        int cnt;
        n = 0;
        for (int j = 0; j < NTAP; j++) begin
            if (mask[j]) n++;
        end
        tgt_c = (n > 0) ? RANK_W'((n - 1) / 2) : '0;
        for (int i = 0; i < NTAP; i++) begin
            cnt = 0;
            for (int j = 0; j < NTAP; j++) begin
                if (mask[j] && ((tap[j] < tap[i]) || (j < i && tap[j] == tap[i]))) cnt++;
            end
            rank_c[i] = RANK_W'(cnt);
        end
    end

    // S2 boundary
    always_ff @(posedge clk) begin
        if (clken) begin
            tap_p1  <= tap;
            mask_p1 <= mask;
            rank_p1 <= rank_c;
            tgt_p1  <= tgt_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else if (clken) begin
            vld_p1  <= tap_vld;
            last_p1 <= tap_vld & tap_last;
        end
    end

    always_comb begin
        sel_c = '0;
        for (int i = 0; i < NTAP; i++) begin
            if (mask_p1[i] && rank_p1[i] == tgt_p1) sel_c = tap_p1[i];
        end
    end

    // S3 boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            med_vld  <= 1'b0;
            med_last <= 1'b0;
            med      <= '0;
        end else if (clken) begin
            med_vld  <= vld_p1;
            med_last <= vld_p1 & last_p1;
            if (vld_p1) med <= sel_c;
        end
    end

endmodule

// File: rtl/median_filter_lb.sv
// Vertical median filter with runtime radius, internal line buffers and self-generated bottom flush.
// Optional MF_INVALID_PASS_EN: invalid centre pixels pass through, invalid neighbours count as missing.
module median_filter_lb
    import median_filter_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int RMAX     = 5,
    parameter int MAX_COLS = 2048,
    parameter int ADDR_W   = 11,
    parameter int RAD_W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic [ADDR_W-1:0] cols,
    input  logic [ADDR_W-1:0] rows,
    input  logic [RAD_W-1:0]  radius,
    input  logic              border_mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_last,
    output logic              busy,
    output logic              cfg_err
);

    localparam int NTAP = 2 * RMAX + 1;
    localparam int NBUF = 2 * RMAX;
    localparam int CW   = ADDR_W + 1;

    state_t state, state_n;

    logic [ADDR_W-1:0] x_q;
    logic [CW-1:0]     y_q;
    logic [CW-1:0]     cols_q;
    logic [ADDR_W-1:0] rows_q;
    logic [RAD_W-1:0]  rad_q;
    logic              bm_q;
    logic [1:0]        drain_cnt;

    int   cols_c, rad_c, cols_e, rows_e, rad_e, xi, yi;
    logic bm_e, size_ok, row_end, last_px, last_fl, adv, emit;

    logic [WIDTH-1:0]           lb [NBUF][MAX_COLS];
    logic [WIDTH-1:0]           tap_raw [NTAP];
    logic [NTAP-1:0][WIDTH-1:0] tap_val, tap_p0;
    logic [NTAP-1:0]            tap_act, mask_p0;
    logic                       vld_p0, last_p0;

    // The frame-opening transfer already uses the incoming config, before it is latched.
    always_comb begin
        cols_c = (int'(cols) > MAX_COLS) ? MAX_COLS : int'(cols);
        rad_c  = (int'(radius) > RMAX) ? RMAX : int'(radius);
        if (state == IDLE) begin
            cols_e = cols_c;
            rows_e = int'(rows);
            rad_e  = rad_c;
            bm_e   = border_mode;
        end else begin
            cols_e = int'(cols_q);
            rows_e = int'(rows_q);
            rad_e  = int'(rad_q);
            bm_e   = bm_q;
        end
        xi      = int'(x_q);
        yi      = int'(y_q);
        size_ok = (cols_e != 0) && (rows_e != 0);
        row_end = (xi == cols_e - 1);
        last_px = row_end && (yi == rows_e - 1);
        last_fl = row_end && (yi == rows_e + rad_e - 1);
        adv     = (in_valid && in_ready && size_ok) || (state == FLUSH);
        emit    = adv && (yi >= rad_e);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else if (clken) state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, RUN: if (in_valid && size_ok)
                state_n = !last_px ? RUN : (rad_e == 0) ? DRAIN : FLUSH;
            FLUSH:     if (last_fl) state_n = DRAIN;
            DRAIN:     if (drain_cnt == 2'd2) state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE) || (state == RUN);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q       <= '0;
            y_q       <= '0;
            cols_q    <= '0;
            rows_q    <= '0;
            rad_q     <= '0;
            bm_q      <= 1'b0;
            drain_cnt <= '0;
            cfg_err   <= 1'b0;
        end else if (clken) begin
            if (state == IDLE && adv) begin
                cols_q  <= CW'(cols_c);
                rows_q  <= rows;
                rad_q   <= RAD_W'(rad_c);
                bm_q    <= border_mode;
                cfg_err <= (int'(radius) > RMAX) || (int'(cols) > MAX_COLS);
            end
            if (adv) begin
                if (row_end) begin
                    x_q <= '0;
                    y_q <= y_q + 1'b1;
                end else begin
                    x_q <= x_q + 1'b1;
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : 2'd0;
            if (state_n == DRAIN && state != DRAIN) begin
                x_q <= '0;
                y_q <= '0;
            end
        end
    end

    // Buffer k holds row y-k-1 at each column; reads see pre-write contents.
    always_ff @(posedge clk) begin
        if (clken && adv) begin
            lb[0][x_q] <= tap_raw[0];
            for (int k = 1; k < NBUF; k++) lb[k][x_q] <= lb[k-1][x_q];
        end
    end

    always_comb begin
        tap_raw[0] = (state == FLUSH) ? '0 : in_data;
        for (int k = 1; k < NTAP; k++) tap_raw[k] = lb[k-1][x_q];
    end

    always_comb begin
        logic tv;
`ifdef MF_INVALID_PASS_EN
        logic ctr_inv;
        ctr_inv = 1'b0;
`endif
        tap_val = '0;
        tap_act = '0;
        for (int k = 0; k < NTAP; k++) begin
            tv = (yi >= k) && (yi < rows_e + k);
`ifdef MF_INVALID_PASS_EN
            if (tap_raw[k] == WIDTH'(INVALID_DISP)) begin
                if (k == rad_e) ctr_inv = ctr_inv | tv;
                else            tv = 1'b0;
            end
`endif
            tap_val[k] = tv ? tap_raw[k] : '0;
            tap_act[k] = (k <= 2 * rad_e) && (tv || !bm_e);
        end
`ifdef MF_INVALID_PASS_EN
        // Masking down to the centre alone makes the median equal the invalid code.
        if (ctr_inv) begin
            for (int k = 0; k < NTAP; k++) tap_act[k] = (k == rad_e);
        end
`endif
    end

    // S1 boundary
    always_ff @(posedge clk) begin
        if (clken) begin
            tap_p0  <= tap_val;
            mask_p0 <= tap_act;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            last_p0 <= 1'b0;
        end else if (clken) begin
            vld_p0  <= emit;
            last_p0 <= emit && last_fl;
        end
    end

    median_rank_select #(
        .WIDTH (WIDTH),
        .NTAP  (NTAP)
    ) u_rank_select (
        .clk      (clk),
        .rst      (rst),
        .clken    (clken),
        .tap_vld  (vld_p0),
        .tap_last (last_p0),
        .tap      (tap_p0),
        .mask     (mask_p0),
        .med_vld  (out_valid),
        .med_last (out_last),
        .med      (out_data)
    );

endmodule

// File: tb/tb_median_filter_lb.sv
// Directed self-checking bench for median_filter_lb with hand-computed expected outputs.
module tb_median_filter_lb;

    localparam int WIDTH  = 9;
    localparam int ADDR_W = 11;
    localparam int RAD_W  = 3;

    logic              clk, rst, clken;
    logic [ADDR_W-1:0] cols, rows;
    logic [RAD_W-1:0]  radius;
    logic              border_mode, in_valid, in_ready;
    logic [WIDTH-1:0]  in_data, out_data;
    logic              out_valid, out_last, busy, cfg_err;

    int checks = 0;
    int errors = 0;
    int ecnt = 0;
    bit ck_edge = 0;
    int hold_cnt;
    int stim[$];
    int exp_q[$];
    int out_d[$];
    bit out_l[$];
    int out_e[$];
    int in_e[$];

    median_filter_lb dut (
        .clk(clk), .rst(rst), .clken(clken), .cols(cols), .rows(rows), .radius(radius),
        .border_mode(border_mode), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
        .cfg_err(cfg_err)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        ecnt    <= ecnt + 1;
        ck_edge <= clken && !rst;
    end

    // An output counts once per advancing edge that left out_valid high.
    always @(negedge clk) begin
        if (out_valid && ck_edge) begin
            out_d.push_back(int'(out_data));
            out_l.push_back(out_last);
            out_e.push_back(ecnt);
        end
    end

    task automatic clear_obs();
        out_d.delete(); out_l.delete(); out_e.delete(); in_e.delete();
    endtask

    task automatic set_cfg(input int c, input int r, input int rad, input bit bm);
        cols = ADDR_W'(c); rows = ADDR_W'(r); radius = RAD_W'(rad); border_mode = bm;
    endtask

    task automatic drive_frame(input bit stall);
        bit tr;
        int guard;
        foreach (stim[i]) begin
            in_valid = 1'b1;
            in_data  = WIDTH'(stim[i]);
            guard    = 0;
            forever begin
                clken = stall ? 1'($urandom_range(0, 1)) : 1'b1;
                tr = in_ready && clken;
                @(posedge clk); #1;
                if (tr) begin
                    in_e.push_back(ecnt);
                    break;
                end
                guard++;
                if (guard > 200) begin
                    errors++;
                    $display("FAIL drive_timeout: pixel %0d not accepted, in_ready %0b", i, in_ready);
                    break;
                end
            end
        end
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_idle(input bit stall);
        int n;
        n = 0;
        hold_cnt = 0;
        while (busy && n < 5000) begin
            clken = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (clken && !in_ready) hold_cnt++;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy %0b after %0d cycles, required 0", busy, n);
        end
        clken = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        checks += 6;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b required 0", out_valid); end
        if (out_data !== '0)    begin errors++; $display("FAIL reset_out_data: got %0d required 0", out_data); end
        if (out_last !== 1'b0)  begin errors++; $display("FAIL reset_out_last: got %0b required 0", out_last); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b required 0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b required 1", in_ready); end
        if (cfg_err !== 1'b0)   begin errors++; $display("FAIL reset_cfg_err: got %0b required 0", cfg_err); end
    endtask

    task automatic test_bypass();
        set_cfg(4, 3, 0, 1'b0);
        stim.delete();
        for (int i = 0; i < 12; i++) stim.push_back(i);
        clear_obs();
        drive_frame(1'b0);
        wait_idle(1'b0);
        checks++;
        if (out_d.size() != 12) begin errors++; $display("FAIL bypass_count: got %0d required 12", out_d.size()); end
        for (int i = 0; i < 12 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== i || out_l[i] !== (i == 11) || out_e[i] - in_e[i] != 2) begin
                errors++;
                $display("FAIL bypass_px[%0d]: got data %0d last %0b lag %0d required data %0d last %0b lag 2",
                         i, out_d[i], out_l[i], out_e[i] - in_e[i], i, (i == 11));
            end
        end
    endtask

    task automatic test_zero_pad();
        set_cfg(1, 5, 1, 1'b0);
        stim = '{5, 5, 5, 5, 5};
        exp_q = '{5, 5, 5, 5, 5};
        clear_obs();
        drive_frame(1'b0);
        wait_idle(1'b0);
        checks++;
        if (out_d.size() != exp_q.size()) begin errors++; $display("FAIL zpad_count: got %0d required %0d", out_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_q[i] || out_l[i] !== (i == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL zpad_px[%0d]: got %0d last %0b required %0d last %0b", i, out_d[i], out_l[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_clamp_stall();
        // Six rows with radius clamped to 5: every window spans the whole column.
        set_cfg(2, 6, 7, 1'b1);
        stim = '{6, 3, 2, 3, 9, 8, 4, 0, 1, 5, 7, 5};
        exp_q = '{4, 3, 4, 3, 4, 3, 4, 3, 4, 3, 4, 3};
        clear_obs();
        drive_frame(1'b1);
        wait_idle(1'b1);
        checks += 2;
        if (cfg_err !== 1'b1) begin errors++; $display("FAIL clamp_cfg_err: got %0b required 1", cfg_err); end
        if (out_d.size() != exp_q.size()) begin errors++; $display("FAIL clamp_count: got %0d required %0d", out_d.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_q[i] || out_l[i] !== (i == exp_q.size() - 1)) begin
                errors++;
                $display("FAIL clamp_px[%0d]: got %0d last %0b required %0d last %0b", i, out_d[i], out_l[i], exp_q[i], (i == exp_q.size() - 1));
            end
        end
    endtask

    task automatic test_exclude();
        set_cfg(1, 3, 2, 1'b1);
        stim = '{9, 1, 4};
        exp_q = '{4, 4, 4};
        clear_obs();
        drive_frame(1'b0);
        wait_idle(1'b0);
        checks += 3;
        // Two flush cycles plus three drain cycles with input blocked.
        if (hold_cnt != 5) begin errors++; $display("FAIL excl_flush_len: got %0d required 5", hold_cnt); end
        if (cfg_err !== 1'b0) begin errors++; $display("FAIL excl_cfg_err: got %0b required 0", cfg_err); end
        if (out_d.size() != 3) begin errors++; $display("FAIL excl_count: got %0d required 3", out_d.size()); end
        for (int i = 0; i < 3 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_q[i] || out_l[i] !== (i == 2)) begin
                errors++;
                $display("FAIL excl_px[%0d]: got %0d last %0b required %0d last %0b", i, out_d[i], out_l[i], exp_q[i], (i == 2));
            end
        end
    endtask

    task automatic test_reset_flush();
        set_cfg(8, 6, 2, 1'b0);
        stim.delete();
        for (int i = 0; i < 48; i++) stim.push_back((i * 5) % 13);
        clear_obs();
        drive_frame(1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstfl_in_flush: got busy %0b in_ready %0b required busy 1 in_ready 0", busy, in_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_obs();
        checks += 3;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rstfl_out_valid: got %0b required 0", out_valid); end
        if (busy !== 1'b0)      begin errors++; $display("FAIL rstfl_busy: got %0b required 0", busy); end
        if (in_ready !== 1'b1)  begin errors++; $display("FAIL rstfl_in_ready: got %0b required 1", in_ready); end
        repeat (8) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_d.size() != 0) begin errors++; $display("FAIL rstfl_quiet: got %0d outputs required 0", out_d.size()); end
        // Next frame over stale line-buffer contents: 2x3, radius 1, exclude mode.
        set_cfg(2, 3, 1, 1'b1);
        stim = '{3, 8, 1, 6, 2, 7};
        exp_q = '{1, 6, 2, 7, 1, 6};
        clear_obs();
        drive_frame(1'b0);
        wait_idle(1'b0);
        checks++;
        if (out_d.size() != 6) begin errors++; $display("FAIL rstfl_count: got %0d required 6", out_d.size()); end
        for (int i = 0; i < 6 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_q[i] || out_l[i] !== (i == 5)) begin
                errors++;
                $display("FAIL rstfl_px[%0d]: got %0d last %0b required %0d last %0b", i, out_d[i], out_l[i], exp_q[i], (i == 5));
            end
        end
    endtask

    task automatic test_zero_size();
        set_cfg(0, 3, 1, 1'b0);
        clear_obs();
        in_valid = 1'b1;
        in_data  = 9'd42;
        clken    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL zsize_busy: got %0b required 0", busy); end
        repeat (5) begin
            @(posedge clk); #1;
        end
        checks++;
        if (out_d.size() != 0) begin errors++; $display("FAIL zsize_quiet: got %0d outputs required 0", out_d.size()); end
    endtask

    task automatic test_invalid();
`ifdef MF_INVALID_PASS_EN
        set_cfg(1, 3, 1, 1'b1);
        exp_q = '{7, 511, 7};
`else
        set_cfg(1, 3, 1, 1'b0);
        exp_q = '{7, 7, 7};
`endif
        stim = '{7, 511, 7};
        clear_obs();
        drive_frame(1'b0);
        wait_idle(1'b0);
        checks++;
        if (out_d.size() != 3) begin errors++; $display("FAIL inv_count: got %0d required 3", out_d.size()); end
        for (int i = 0; i < 3 && i < out_d.size(); i++) begin
            checks++;
            if (out_d[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL inv_px[%0d]: got %0d required %0d", i, out_d[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; clken = 1'b1; in_valid = 1'b0; in_data = '0;
        set_cfg(0, 0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_bypass();
        test_zero_pad();
        test_clamp_stall();
        test_exclude();
        test_reset_flush();
        test_zero_size();
        test_invalid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
